rate_timer: RTL and testbench
=============================

Name: rate_timer

Overview:
Parametrised successor to the game's single-rate flash timer. Generates a periodic or one-shot terminal-count pulse at one of NUM_SPEEDS binary-scaled rates (BASE_HZ << speed), plus a 50% duty flash phase, pause/hold and a saturating pulse counter. The FSM uses it to pace colour playback and player-turn timeouts, and the LED driver uses on_phase directly.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
BASE_HZ, 1, slowest rate (speed 0) in Hz
NUM_SPEEDS, 5, number of legal speed codes, 0..NUM_SPEEDS-1; each step doubles the rate
SPD_W, 3, width of the speed code
PCNT_W, 6, width of the pulse counter

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-high reset
load  input  1  latch speed/oneshot, restart the period, clear the pulse counter
speed  input  SPD_W  requested rate code, sampled only on load
oneshot  input  1  sampled on load; 1 = single pulse then idle, 0 = periodic
pause  input  1  level; freezes counting while high
pulse  output  1  one-cycle terminal-count strobe
on_phase  output  1  high during the first half of each period while active
busy  output  1  high in RUN or HOLD
cur_speed  output  SPD_W  latched, clamped speed code
pulses  output  PCNT_W  pulses since last load, saturating

Behaviour:
- CNT_W = $clog2(CLK_HZ/BASE_HZ). Period for speed s: P_s = (CLK_HZ/BASE_HZ) >> s. Reload R_s = P_s - 1, floored at 1 (minimum period 2).
- Clamp: speed >= NUM_SPEEDS latches as NUM_SPEEDS-1; cur_speed shows the clamped value.
- States: IDLE, RUN, HOLD.
- Reset (async, any state): state IDLE, counter 0, cur_speed 0, oneshot latch 0, pulses 0. pulse, on_phase and busy are 0 immediately.
- load (any state): counter <= R_s, latch speed and oneshot, pulses <= 0, state <= RUN. pulse is suppressed in the load cycle even if counter==0.
- RUN, pause=0: counter decrements each cycle.
- RUN, counter==0: pulse=1 combinationally (pulse = RUN & ~pause & ~load & counter==0). On the next edge, pulses increments, saturating at all-ones.
  - periodic: counter <= R_s, stay in RUN.
  - oneshot: counter <= R_s, state <= IDLE.
- First pulse occurs P_s cycles after the load edge; subsequent pulses are every P_s cycles.
- RUN with pause=1: state <= HOLD and the counter holds. pulse is suppressed, including when counter==0.
- HOLD: counter frozen. pause=0 returns to RUN and resumes from the frozen count. Total delay added equals the number of paused cycles.
- on_phase = busy & (counter >= (R_s+1)/2). At speed with R=7 it is high for counts 7..4 and low for 3..0. on_phase is held while in HOLD.
- IDLE: counter holds; pulse=0, on_phase=0, busy=0. pulses keeps its value until the next load.
- cur_speed and the oneshot latch change only on load or reset.

Optional Feature:
RATE_TIMER_STOP_EN:
- Defined: adds input port stop (1 bit). stop=1 forces state <= IDLE and counter <= 0 on the next edge; pulses keeps its value. pulse is suppressed in the stop cycle. If stop and load are asserted together, stop wins.
- Undefined: no stop port. The only exits from RUN/HOLD are oneshot completion and reset.

Test Plan:
(All with CLK_HZ=32, BASE_HZ=1, NUM_SPEEDS=5, giving periods 32/16/8/4/2.)
1. load speed=2, oneshot=0 -> pulse on cycles 8, 16, 24 after the load edge; on_phase pattern 4 high / 4 low; pulses reads 1, 2, 3.
2. load speed=0, oneshot=1 -> single pulse at cycle 32; busy=0 from cycle 33; pulses=1; no further pulses over 100 cycles.
3. load speed=3, then pause high for 5 cycles starting at counter==0 -> no pulse during pause; pulse arrives exactly 5 cycles late; period then returns to 4.
4. load speed=7 -> cur_speed=4, pulse every 2 cycles. Re-assert load in a pulse cycle -> no pulse that cycle; pulses=0; next pulse 2 cycles later.
5. Assert reset asynchronously mid-RUN, between clock edges -> busy, pulse, on_phase and pulses go to 0 before the next edge; state IDLE after release.
6. With RATE_TIMER_STOP_EN defined, assert stop and load in the same cycle during RUN -> IDLE, no pulse, pulses retains its prior value.

Source files
------------

// File: rtl/rate_timer.sv
// rate_timer: binary-scaled periodic / one-shot tick generator with flash phase.
// Optional stop input is compiled in when RATE_TIMER_STOP_EN is defined.
module rate_timer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BASE_HZ    = 1,
  parameter int NUM_SPEEDS = 5,
  parameter int SPD_W      = 3,
  parameter int PCNT_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SPD_W-1:0]  speed,
  input  logic              oneshot,
  input  logic              pause,
`ifdef RATE_TIMER_STOP_EN
  input  logic              stop,
`endif
  output logic              pulse,
  output logic              on_phase,
  output logic              busy,
  output logic [SPD_W-1:0]  cur_speed,
  output logic [PCNT_W-1:0] pulses
);

  localparam int PER0  = CLK_HZ / BASE_HZ;
  localparam int CNT_W = (PER0 > 2) ? $clog2(PER0) : 1;
  localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(NUM_SPEEDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Reload value for a speed code: period minus one, never below 1.
  function automatic logic [CNT_W-1:0] reload_of(input logic [SPD_W-1:0] s);
    int p;
    p = PER0 >> s;
    if (p < 2) p = 2;
    return CNT_W'(p - 1);
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SPD_W-1:0]    spd_q, spd_d;
  logic                os_q, os_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [SPD_W-1:0]    spd_clamp;
  logic [CNT_W-1:0]    reload;
  logic [CNT_W:0]      half;
  logic                stop_i;
  logic                run;
  logic                tc;

`ifdef RATE_TIMER_STOP_EN
  assign stop_i = stop;
`else
  assign stop_i = 1'b0;
`endif

  assign spd_clamp = (speed > MAX_SPD) ? MAX_SPD : speed;
  assign reload    = reload_of(spd_q);
  assign half      = ({1'b0, reload} + (CNT_W+1)'(1)) >> 1;

  // HOLD with pause released resumes counting in that same cycle,
  // so the added delay equals exactly the number of paused cycles.
  assign busy      = (state_q != IDLE);
  assign run       = busy & ~pause;
  assign tc        = (cnt_q == '0);
  assign pulse     = run & ~load & ~stop_i & tc;
  assign on_phase  = busy & ({1'b0, cnt_q} >= half);
  assign cur_speed = spd_q;
  assign pulses    = pcnt_q;

  // Next-state and datapath updates; stop beats load, load beats counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spd_d   = spd_q;
    os_d    = os_q;
    pcnt_d  = pcnt_q;
    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d = RUN;
      cnt_d   = reload_of(spd_clamp);
      spd_d   = spd_clamp;
      os_d    = oneshot;
      pcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN, HOLD: begin
          if (pause) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
            if (tc) begin
              cnt_d = reload;
              if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
              if (os_q) state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spd_q   <= '0;
      os_q    <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spd_q   <= spd_d;
      os_q    <= os_d;
      pcnt_q  <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_rate_timer.sv
// tb_rate_timer: directed and random checks of rate_timer
// against a period-position reference model (CLK_HZ=32, BASE_HZ=1).
module tb_rate_timer;

  localparam int CLK_HZ = 32;
  localparam int NSPD   = 5;
`ifdef RATE_TIMER_STOP_EN
  localparam bit HAS_STOP = 1'b1;
`else
  localparam bit HAS_STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       oneshot = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic       pulse, on_phase, busy;
  logic [2:0] cur_speed;
  logic [5:0] pulses;

  int checks = 0;
  int errors = 0;

  rate_timer #(
    .CLK_HZ(CLK_HZ),
    .BASE_HZ(1),
    .NUM_SPEEDS(NSPD),
    .SPD_W(3),
    .PCNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .speed(speed),
    .oneshot(oneshot),
    .pause(pause),
`ifdef RATE_TIMER_STOP_EN
    .stop(stop),
`endif
    .pulse(pulse),
    .on_phase(on_phase),
    .busy(busy),
    .cur_speed(cur_speed),
    .pulses(pulses)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {pulse, on_phase, busy, cur_speed, pulses};

  // Reference model: position k (1..P) of the current cycle inside its period.
  bit   m_act = 0;
  bit   m_os = 0;
  int   m_k = 1;
  int   m_p = 2;
  int   m_pc = 0;
  int   m_spd = 0;
  logic [11:0] expv;

  function automatic int clampf(input int s);
    return (s > NSPD - 1) ? NSPD - 1 : s;
  endfunction

  function automatic int perf(input int s);
    int p;
    p = CLK_HZ / (1 << s);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_edge;
    bit st;
    st = HAS_STOP && stop;
    if (reset) begin
      m_act = 0; m_pc = 0; m_spd = 0; m_os = 0; m_k = 1;
    end else if (st) begin
      m_act = 0;
    end else if (load) begin
      m_act = 1;
      m_spd = clampf(int'(speed));
      m_p   = perf(m_spd);
      m_k   = 1;
      m_pc  = 0;
      m_os  = oneshot;
    end else if (m_act && !pause) begin
      if (m_k == m_p) begin
        m_k = 1;
        if (m_pc < 63) m_pc++;
        if (m_os) m_act = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic model_expect;
    bit ep, eo, st;
    st = HAS_STOP && stop;
    ep = m_act && !pause && !load && !st && (m_k == m_p);
    eo = m_act && (m_k <= m_p / 2);
    expv = {ep, eo, m_act, 3'(m_spd), 6'(m_pc)};
  endtask

  task automatic cyc(input logic ld, input logic [2:0] sp,
                     input logic os, input logic ps, input logic st);
    @(posedge clk);
    model_edge();
    #1;
    load = ld; speed = sp; oneshot = os; pause = ps;
    stop = st & HAS_STOP;
    @(negedge clk);
    model_expect();
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (obs !== 12'b0) begin
      errors++;
      $display("FAIL reset_state: got %b exp %b", obs, 12'b0);
    end
    cyc(0, 3'd0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) begin
      cyc(0, 3'd0, 0, 0, 0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_idle: got %b exp %b", obs, expv);
      end
    end
  endtask

  task automatic test_periodic;
    int q[$];
    int on_cnt;
    on_cnt = 0;
    cyc(1, 3'd2, 0, 0, 0);
    for (int n = 1; n <= 26; n++) begin
      cyc(0, 3'd2, 0, 0, 0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL periodic n=%0d: got %b exp %b", n, obs, expv);
      end
      if (pulse) q.push_back(n);
      if (n <= 8 && on_phase) on_cnt++;
    end
    checks++;
    if (q.size() != 3 || q[0] != 8 || q[1] != 16 || q[2] != 24) begin
      errors++;
      $display("FAIL periodic_times: got %p exp '{8,16,24}", q);
    end
    checks++;
    if (on_cnt != 4 || pulses !== 6'd3) begin
      errors++;
      $display("FAIL periodic_on_pulses: on=%0d pulses=%0d exp 4 3",
               on_cnt, pulses);
    end
  endtask

  task automatic test_oneshot;
    int q[$];
    bit idle33;
    idle33 = 0;
    cyc(1, 3'd0, 1, 0, 0);
    for (int n = 1; n <= 132; n++) begin
      cyc(0, 3'd0, 0, 0, 0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL oneshot n=%0d: got %b exp %b", n, obs, expv);
      end
      if (pulse) q.push_back(n);
      if (n == 33) idle33 = !busy;
    end
    checks++;
    if (q.size() != 1 || q[0] != 32 || !idle33 || pulses !== 6'd1) begin
      errors++;
      $display("FAIL oneshot_summary: got %p idle33=%0d pulses=%0d exp '{32} 1 1",
               q, idle33, pulses);
    end
  endtask

  task automatic test_pause;
    int q[$];
    logic ps;
    cyc(1, 3'd3, 0, 0, 0);
    for (int n = 1; n <= 22; n++) begin
      ps = (n >= 8 && n <= 12);
      cyc(0, 3'd3, 0, ps, 0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL pause n=%0d: got %b exp %b", n, obs, expv);
      end
      if (pulse) q.push_back(n);
    end
    checks++;
    if (q.size() != 4 || q[0] != 4 || q[1] != 13 || q[2] != 17 || q[3] != 21) begin
      errors++;
      $display("FAIL pause_times: got %p exp '{4,13,17,21}", q);
    end
  endtask

  task automatic test_clamp_reload;
    cyc(1, 3'd7, 0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      cyc((n == 4), 3'd7, 0, 0, 0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL clamp n=%0d: got %b exp %b", n, obs, expv);
      end
      if (n == 1 && cur_speed !== 3'd4) begin
        errors++;
        $display("FAIL clamp_speed: got %0d exp 4", cur_speed);
      end
      if (n == 4 && pulse !== 1'b0) begin
        errors++;
        $display("FAIL reload_nopulse: got %b exp 0", pulse);
      end
      if (n == 5 && pulses !== 6'd0) begin
        errors++;
        $display("FAIL reload_clear: got %0d exp 0", pulses);
      end
      if (n == 6 && pulse !== 1'b1) begin
        errors++;
        $display("FAIL reload_next: got %b exp 1", pulse);
      end
    end
  endtask

  task automatic test_async_reset;
    cyc(1, 3'd3, 0, 0, 0);
    repeat (6) cyc(0, 3'd3, 0, 0, 0);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL areset_pre: got %b exp %b", obs, expv);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 12'b0) begin
      errors++;
      $display("FAIL areset_now: got %b exp %b", obs, 12'b0);
    end
    cyc(0, 3'd3, 0, 0, 0);
    reset = 1'b0;
    repeat (3) begin
      cyc(0, 3'd3, 0, 0, 0);
      checks++;
      if (obs !== expv || busy !== 1'b0) begin
        errors++;
        $display("FAIL areset_after: got %b exp %b", obs, expv);
      end
    end
  endtask

`ifdef RATE_TIMER_STOP_EN
  task automatic test_stop;
    cyc(1, 3'd2, 0, 0, 0);
    repeat (10) cyc(0, 3'd2, 0, 0, 0);
    cyc(1, 3'd1, 0, 0, 1);
    checks++;
    if (pulse !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL stop_cycle: got %b exp %b", obs, expv);
    end
    cyc(0, 3'd1, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || pulses !== 6'd1 || obs !== expv) begin
      errors++;
      $display("FAIL stop_after: got %b exp %b", obs, expv);
    end
  endtask
`endif

  task automatic test_random;
    logic ld, os, ps, st;
    logic [2:0] sp;
    for (int i = 0; i < 1500; i++) begin
      ld = ($urandom_range(0, 29) == 0);
      sp = 3'($urandom_range(0, 7));
      os = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 149) == 0);
      cyc(ld, sp, os, ps, st);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random i=%0d: got %b exp %b", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_clamp_reload();
    test_async_reset();
`ifdef RATE_TIMER_STOP_EN
    test_stop();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
